sw_job_ctrl: RTL and testbench



---
 rtl/sw_job_ctrl_if.sv | 61 ++++++
 rtl/sw_job_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sw_job_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_job_ctrl_if.sv
// Job/engine bundle for sw_job_ctrl: job push side, engine launch/result side and
// the derived scoring constants. err_o exists only when SW_JOB_TIMEOUT_EN is defined.
interface sw_job_ctrl_if #(
    parameter int MATCH_W = 4,
    parameter int CALC_W  = 12,
    parameter int ADDR_W  = 10,
    parameter int IDX_W   = 8
);
    logic                start_i;
    logic                ready_o;
    logic [MATCH_W-1:0]  match_i;
    logic [MATCH_W-1:0]  mismatch_i;
    logic [MATCH_W-1:0]  alpha_i;
    logic [MATCH_W-1:0]  beta_i;
    logic [ADDR_W-1:0]   t_base_i;
    logic [ADDR_W-1:0]   q_base_i;
    logic                busy_o;
    logic                eng_start_o;
    logic                eng_busy_i;
    logic [CALC_W-1:0]   match_o;
    logic [CALC_W-1:0]   mismatch_o;
    logic [CALC_W-1:0]   alpha_o;
    logic [CALC_W-1:0]   beta_o;
    logic [CALC_W-1:0]   a2_o;
    logic [CALC_W-1:0]   ab_o;
    logic [CALC_W-1:0]   ma_a_o;
    logic [CALC_W-1:0]   mis_a_o;
    logic [ADDR_W-1:0]   t_base_o;
    logic [ADDR_W-1:0]   q_base_o;
    logic                res_valid_i;
    logic [CALC_W-1:0]   res_i;
    logic [IDX_W-1:0]    res_idx_i;
    logic                done_o;
    logic [CALC_W-1:0]   done_max_o;
    logic [IDX_W-1:0]    done_idx_o;
`ifdef SW_JOB_TIMEOUT_EN
    logic                err_o;
`endif

    modport master (
        output start_i, match_i, mismatch_i, alpha_i, beta_i, t_base_i, q_base_i,
        output eng_busy_i, res_valid_i, res_i, res_idx_i,
        input  ready_o, busy_o, eng_start_o,
        input  match_o, mismatch_o, alpha_o, beta_o, a2_o, ab_o, ma_a_o, mis_a_o,
        input  t_base_o, q_base_o, done_o, done_max_o, done_idx_o
`ifdef SW_JOB_TIMEOUT_EN
        , input err_o
`endif
    );

    modport slave (
        input  start_i, match_i, mismatch_i, alpha_i, beta_i, t_base_i, q_base_i,
        input  eng_busy_i, res_valid_i, res_i, res_idx_i,
        output ready_o, busy_o, eng_start_o,
        output match_o, mismatch_o, alpha_o, beta_o, a2_o, ab_o, ma_a_o, mis_a_o,
        output t_base_o, q_base_o, done_o, done_max_o, done_idx_o
`ifdef SW_JOB_TIMEOUT_EN
        , output err_o
`endif
    );
endinterface

// File: rtl/sw_job_ctrl.sv
// Queued job sequencer for the Smith-Waterman engine: derives signed scoring constants,
// launches runs back-to-back and tracks the best score. Optional watchdog: SW_JOB_TIMEOUT_EN.
module sw_job_ctrl #(
    parameter int MATCH_W   = 4,
    parameter int CALC_W    = 12,
    parameter int ADDR_W    = 10,
    parameter int IDX_W     = 8,
    parameter int JOB_DEPTH = 4
`ifdef SW_JOB_TIMEOUT_EN
    , parameter int TIMEOUT = 1024
`endif
) (
    input logic           clk,
    input logic           rst,
    sw_job_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(JOB_DEPTH);
    localparam int ENT_W = 4*MATCH_W + 2*ADDR_W;
    // Two headroom bits: -2a and -(a+b) reach -2*(2^MATCH_W-1).
    localparam int EW    = MATCH_W + 2;

    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_BUSY, RUN, DONE} state_t;
    state_t state_reg, state_next;

    logic [ENT_W-1:0]  mem [JOB_DEPTH];
    logic [ENT_W-1:0]  rd_data_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              push, pop, in_wait;

    assign bus.ready_o = (count_reg != (PTR_W+1)'(JOB_DEPTH));
    assign push        = bus.start_i & bus.ready_o;
    assign pop         = (state_reg == IDLE) && (count_reg != '0);
    assign in_wait     = (state_reg == WAIT_BUSY) || (state_reg == RUN);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {bus.match_i, bus.mismatch_i, bus.alpha_i, bus.beta_i,
                                bus.t_base_i, bus.q_base_i};
        if (pop)
            rd_data_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef SW_JOB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             tmo_hit, tmo_force, tmo_flag_reg;

    assign tmo_hit   = in_wait && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
    // A run that ends naturally on the last allowed cycle is not an error.
    assign tmo_force = tmo_hit && !((state_reg == RUN) && !bus.eng_busy_i);

    always_ff @(posedge clk) begin
        if (rst || !in_wait) tmo_cnt_reg <= '0;
        else                 tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        if (rst) tmo_flag_reg <= 1'b0;
        else     tmo_flag_reg <= tmo_force;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (count_reg != '0) state_next = LOAD;
            LOAD:      state_next = KICK;
            KICK:      state_next = WAIT_BUSY;
            WAIT_BUSY: if (bus.eng_busy_i) state_next = RUN;
            RUN:       if (!bus.eng_busy_i) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
`ifdef SW_JOB_TIMEOUT_EN
        if (tmo_hit) state_next = DONE;
`endif
    end

    logic eng_start, done;
    always_comb begin
        eng_start = 1'b0;
        done      = 1'b0;
        case (state_reg)
            KICK:    eng_start = 1'b1;
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    assign bus.eng_start_o = eng_start;
    assign bus.done_o      = done;
    assign bus.busy_o      = (state_reg != IDLE) || (count_reg != '0);
`ifdef SW_JOB_TIMEOUT_EN
    assign bus.err_o       = done & tmo_flag_reg;
`endif

    logic [MATCH_W-1:0] ld_m, ld_x, ld_a, ld_b;
    logic [ADDR_W-1:0]  ld_t, ld_q;
    logic [EW-1:0]      zm, zx, za, zb;
    logic [EW-1:0]      raw [8];

    assign {ld_m, ld_x, ld_a, ld_b, ld_t, ld_q} = rd_data_reg;

    always_comb begin
        zm     = {2'b00, ld_m};
        zx     = {2'b00, ld_x};
        za     = {2'b00, ld_a};
        zb     = {2'b00, ld_b};
        raw[0] = zm;
        raw[1] = '0 - zx;
        raw[2] = '0 - za;
        raw[3] = '0 - zb;
        raw[4] = '0 - (za + za);
        raw[5] = '0 - (za + zb);
        raw[6] = zm - za;
        raw[7] = '0 - (zx + za);
    end

    // Constants are sign-extended and captured once per job in LOAD.
    for (genvar gi = 0; gi < 8; gi++) begin : g_const
        logic [CALC_W-1:0] c_reg;
        always_ff @(posedge clk) begin
            if (rst)                    c_reg <= '0;
            else if (state_reg == LOAD) c_reg <= {{(CALC_W-EW){raw[gi][EW-1]}}, raw[gi]};
        end
    end

    assign bus.match_o    = g_const[0].c_reg;
    assign bus.mismatch_o = g_const[1].c_reg;
    assign bus.alpha_o    = g_const[2].c_reg;
    assign bus.beta_o     = g_const[3].c_reg;
    assign bus.a2_o       = g_const[4].c_reg;
    assign bus.ab_o       = g_const[5].c_reg;
    assign bus.ma_a_o     = g_const[6].c_reg;
    assign bus.mis_a_o    = g_const[7].c_reg;

    logic signed [CALC_W-1:0] max_reg, max_upd, done_max_reg;
    logic [IDX_W-1:0]         idx_reg, idx_upd, done_idx_reg;
    logic [ADDR_W-1:0]        t_base_reg, q_base_reg;

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        max_upd = max_reg;
        idx_upd = idx_reg;
        if (in_wait && bus.res_valid_i && ($signed(bus.res_i) > max_reg)) begin
            max_upd = $signed(bus.res_i);
            idx_upd = bus.res_idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_reg      <= '0;
            idx_reg      <= '0;
            done_max_reg <= '0;
            done_idx_reg <= '0;
            t_base_reg   <= '0;
            q_base_reg   <= '0;
        end else begin
            if (state_reg == LOAD) begin
                max_reg    <= '0;
                idx_reg    <= '0;
                t_base_reg <= ld_t;
                q_base_reg <= ld_q;
            end else begin
                max_reg <= max_upd;
                idx_reg <= idx_upd;
            end
            if ((state_next == DONE) && (state_reg != DONE)) begin
                done_max_reg <= max_upd;
                done_idx_reg <= idx_upd;
            end
        end
    end

    assign bus.t_base_o   = t_base_reg;
    assign bus.q_base_o   = q_base_reg;
    assign bus.done_max_o = done_max_reg;
    assign bus.done_idx_o = done_idx_reg;
endmodule

// File: tb/tb_sw_job_ctrl.sv
// Scoreboard bench for sw_job_ctrl: expected constants are queued at push time and
// checked at each engine launch; best-score results are checked at each done pulse.
module tb_sw_job_ctrl;
    localparam int MATCH_W = 4, CALC_W = 12, ADDR_W = 10, IDX_W = 8, JOB_DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sw_job_ctrl_if #(.MATCH_W(MATCH_W), .CALC_W(CALC_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    sw_job_ctrl #(.MATCH_W(MATCH_W), .CALC_W(CALC_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                  .JOB_DEPTH(JOB_DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [8*CALC_W-1:0] c;
        logic [ADDR_W-1:0]   t;
        logic [ADDR_W-1:0]   q;
    } exp_t;
    typedef struct { int v; int idx; } strobe_t;

    exp_t    sb[$];
    strobe_t sq[$];
    int      err_cnt = 0;
    int      chk_cnt = 0;
    int      exp_max, exp_idx;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CALC_W-1:0] cw(int v);
        logic [31:0] w;
        w = v;
        return w[CALC_W-1:0];
    endfunction

    function automatic exp_t model(int m, int x, int a, int b, int t, int q);
        exp_t e;
        e.c = {cw(m), cw(-x), cw(-a), cw(-b), cw(-2*a), cw(-(a+b)), cw(m-a), cw(-(x+a))};
        e.t = ADDR_W'(t);
        e.q = ADDR_W'(q);
        return e;
    endfunction

    // Drives one push for a cycle; the caller drops start_i after the last one.
    task automatic drive_push(int m, int x, int a, int b, int t, int q, bit accept);
        bus.start_i    = 1'b1;
        bus.match_i    = MATCH_W'(m);
        bus.mismatch_i = MATCH_W'(x);
        bus.alpha_i    = MATCH_W'(a);
        bus.beta_i     = MATCH_W'(b);
        bus.t_base_i   = ADDR_W'(t);
        bus.q_base_i   = ADDR_W'(q);
        chk("push_ready", {31'd0, bus.ready_o}, {31'd0, accept});
        if (accept) sb.push_back(model(m, x, a, b, t, q));
        $display("push m=%0d x=%0d a=%0d b=%0d accept=%0d cyc=%0d", m, x, a, b, accept, cyc);
        @(negedge clk);
    endtask

    task automatic await_kick(string tag, int ref_cyc);
        int   n = 0;
        exp_t e;
        logic [8*CALC_W-1:0] got;
        while (bus.eng_start_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.eng_start_o !== 1'b1) begin
            chk({tag, "_kick_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_kick_lat"}, cyc - ref_cyc, 32'd3);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e   = sb.pop_front();
            got = {bus.match_o, bus.mismatch_o, bus.alpha_o, bus.beta_o,
                   bus.a2_o, bus.ab_o, bus.ma_a_o, bus.mis_a_o};
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s_const%0d", tag, 7 - i),
                    32'(got[i*CALC_W +: CALC_W]), 32'(e.c[i*CALC_W +: CALC_W]));
            chk({tag, "_t_base"}, 32'(bus.t_base_o), 32'(e.t));
            chk({tag, "_q_base"}, 32'(bus.q_base_o), 32'(e.q));
        end
        // A strobe outside WAIT_BUSY/RUN must not touch the max.
        bus.res_valid_i = 1'b1;
        bus.res_i       = cw(100);
        bus.res_idx_i   = 8'hEE;
        @(negedge clk);
        bus.res_valid_i = 1'b0;
        chk({tag, "_kick_pulse"}, {31'd0, bus.eng_start_o}, 32'd0);
    endtask

    task automatic engine_run();
        repeat (2) @(negedge clk);
        bus.eng_busy_i = 1'b1;
        @(negedge clk);
        exp_max = 0;
        exp_idx = 0;
        foreach (sq[i]) begin
            bus.res_valid_i = 1'b1;
            bus.res_i       = cw(sq[i].v);
            bus.res_idx_i   = IDX_W'(sq[i].idx);
            if (sq[i].v > exp_max) begin
                exp_max = sq[i].v;
                exp_idx = sq[i].idx;
            end
            @(negedge clk);
        end
        bus.res_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic engine_finish(string tag, output int done_cyc);
        bus.eng_busy_i = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd1);
        chk({tag, "_done_max"}, 32'(bus.done_max_o), 32'(cw(exp_max)));
        chk({tag, "_done_idx"}, 32'(bus.done_idx_o), 32'(exp_idx));
        done_cyc = cyc;
        $display("job %s done max=%0d idx=%0d cyc=%0d", tag, exp_max, exp_idx, cyc);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, bus.done_o}, 32'd0);
        chk({tag, "_max_hold"}, 32'(bus.done_max_o), 32'(cw(exp_max)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d, n_kick, n_done;
        bus.start_i = 1'b0; bus.match_i = '0; bus.mismatch_i = '0; bus.alpha_i = '0;
        bus.beta_i = '0; bus.t_base_i = '0; bus.q_base_i = '0; bus.eng_busy_i = 1'b0;
        bus.res_valid_i = 1'b0; bus.res_i = '0; bus.res_idx_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_start", {31'd0, bus.eng_start_o}, 32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_match", 32'(bus.match_o), 32'd0);
        chk("rst_dmax", 32'(bus.done_max_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic job with tie and negative results.
        sq = '{'{7, 3}, '{9, 5}, '{9, 8}, '{-2, 9}};
        c0 = cyc;
        drive_push(2, 1, 3, 1, 'h12, 'h34, 1'b1);
        bus.start_i = 1'b0;
        await_kick("jobA", c0);
        engine_run();
        engine_finish("jobA", d);

        // Extreme magnitudes.
        sq = '{'{5, 1}, '{-7, 2}, '{5, 4}};
        c0 = cyc;
        drive_push(15, 15, 15, 15, 'h3FF, 'h200, 1'b1);
        bus.start_i = 1'b0;
        await_kick("jobB", c0);
        engine_run();
        engine_finish("jobB", d);

        // m=15, a=0; only negative results so the max stays at 0, index 0.
        sq = '{'{-3, 1}, '{-1, 2}};
        c0 = cyc;
        drive_push(15, 0, 0, 0, 'h001, 'h002, 1'b1);
        bus.start_i = 1'b0;
        await_kick("jobC", c0);
        engine_run();
        engine_finish("jobC", d);

        // Fill the queue while a job runs; the fifth push is dropped.
        sq = '{'{4, 1}};
        c0 = cyc;
        drive_push(1, 2, 3, 4, 'h010, 'h020, 1'b1);
        bus.start_i = 1'b0;
        await_kick("job0", c0);
        engine_run();
        for (int i = 0; i < 5; i++)
            drive_push(i + 3, i + 1, i, 4 - i, 'h100 + i, 'h180 + i, (i < 4));
        bus.start_i = 1'b0;
        chk("full_busy", {31'd0, bus.busy_o}, 32'd1);
        engine_finish("job0", d);
        for (int j = 0; j < 4; j++) begin
            sq = '{'{j + 2, j + 10}, '{j + 1, j + 20}};
            await_kick($sformatf("jobQ%0d", j), d);
            engine_run();
            engine_finish($sformatf("jobQ%0d", j), d);
        end
        n_kick = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.eng_start_o === 1'b1) n_kick++;
        end
        chk("dropped_no_kick", n_kick, 32'd0);
        chk("drain_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);

        // Reset mid-run with two jobs queued.
        sq = '{};
        c0 = cyc;
        drive_push(3, 3, 3, 3, 'h050, 'h060, 1'b1);
        bus.start_i = 1'b0;
        await_kick("jobR", c0);
        engine_run();
        drive_push(5, 1, 1, 1, 'h070, 'h080, 1'b1);
        drive_push(6, 1, 1, 1, 'h090, 'h0A0, 1'b1);
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("mrst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("mrst_ready", {31'd0, bus.ready_o}, 32'd1);
        chk("mrst_start", {31'd0, bus.eng_start_o}, 32'd0);
        chk("mrst_done", {31'd0, bus.done_o}, 32'd0);
        chk("mrst_match", 32'(bus.match_o), 32'd0);
        rst = 1'b0;
        bus.eng_busy_i = 1'b0;
        n_kick = 0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.eng_start_o === 1'b1) n_kick++;
            if (bus.done_o === 1'b1) n_done++;
        end
        chk("mrst_no_kick", n_kick, 32'd0);
        chk("mrst_no_done", n_done, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
